xgriscv_fetch_queue: RTL and testbench

//  Parametrised fetch stage for the xgriscv pipeline. Owns the PC and issues

---
 rtl/xgriscv_fetch_queue_pkg.sv | 16 +
 rtl/xgriscv_fetch_queue_if.sv | 41 ++++
 rtl/xgriscv_fetch_queue_fifo.sv | 76 +++++++
 rtl/xgriscv_fetch_queue.sv | 88 ++++++++
 tb/tb_xgriscv_fetch_queue.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/xgriscv_fetch_queue_pkg.sv
// Shared constants and helpers for the xgriscv fetch queue.
package xgriscv_fetch_queue_pkg;

    localparam int ADDR_SIZE    = 32;
    localparam int INSTR_SIZE   = 32;
    localparam int FETCHQ_DEPTH = 4;

    // Canonical RISC-V nop: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True for powers of two that are at least 2
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/xgriscv_fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response, EX redirect and decode handshake.
interface xgriscv_fetch_queue_if
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int ADDR_W  = ADDR_SIZE,
    parameter int INSTR_W = INSTR_SIZE,
    parameter int DEPTH   = FETCHQ_DEPTH
);
    logic [ADDR_W-1:0]        imem_addr;
    logic                     imem_req;
    logic                     imem_valid;
    logic [INSTR_W-1:0]       imem_rdata;
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     dec_valid;
    logic                     dec_ready;
    logic [INSTR_W-1:0]       dec_instr;
    logic [ADDR_W-1:0]        dec_pc;
    logic [ADDR_W-1:0]        dec_pcplus4;
    logic [$clog2(DEPTH):0]   q_count;

    // The fetch stage itself
    modport master (
        output imem_addr, imem_req,
        input  imem_valid, imem_rdata,
        input  redirect, redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr, dec_pc, dec_pcplus4, q_count
    );

    // Memory, EX and decode around the fetch stage
    modport slave (
        input  imem_addr, imem_req,
        output imem_valid, imem_rdata,
        output redirect, redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr, dec_pc, dec_pcplus4, q_count
    );
endinterface

// File: rtl/xgriscv_fetch_queue_fifo.sv
// Register-array FIFO with synchronous clear and wrap-around pointers.
module fetch_fifo
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("fetch_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state: clear wins over push/pop; otherwise pointers step and count tracks push - pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers, emptied by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/xgriscv_fetch_queue.sv
// Fetch stage: owns pcF, issues imem requests and queues {pc, pc+4, instr} for decode.
module xgriscv_fetch_queue
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_SIZE,
    parameter int                INSTR_W  = INSTR_SIZE,
    parameter int                DEPTH    = FETCHQ_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                reset,
    xgriscv_fetch_queue_if.master fq
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = 2 * ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               q_full;
    logic               q_empty;
    logic [CNT_W-1:0]   q_cnt;
    logic               req;
    logic               push;
    logic               pop;

    // Request/push/pop decisions; redirect suppresses both fetch and enqueue
    always_comb begin
        pop  = ~q_empty & fq.dec_ready;
        req  = ~reset & ~fq.redirect & (~q_full | pop);
        push = req & fq.imem_valid & ~fq.redirect;
    end

    // Next PC: redirect target first, then sequential advance on a successful push
    always_comb begin
        pc_d = pc_q;
        if (fq.redirect) begin
            pc_d = fq.redirect_pc;
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    // PC register, restarts at RESET_PC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign wr_entry = {pc_q, pc_q + ADDR_W'(4), fq.imem_rdata};

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (fq.redirect),
        .wdata (wr_entry),
        .rdata (head_entry),
        .full  (q_full),
        .empty (q_empty),
        .count (q_cnt)
    );

    // Decode-facing head view; an empty queue presents a nop at pc 0
    always_comb begin
        fq.dec_valid   = ~q_empty;
        fq.dec_instr   = INSTR_W'(NOP_INSTR);
        fq.dec_pc      = '0;
        fq.dec_pcplus4 = '0;
        if (!q_empty) begin
            fq.dec_instr   = head_entry[INSTR_W-1:0];
            fq.dec_pcplus4 = head_entry[INSTR_W +: ADDR_W];
            fq.dec_pc      = head_entry[ENTRY_W-1 -: ADDR_W];
        end
    end

    assign fq.imem_addr = pc_q;
    assign fq.imem_req  = req;
    assign fq.q_count   = q_cnt;

endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// Directed bench for the fetch queue: fill, stream, full+pop, redirect, wait states, reset.
module tb_xgriscv_fetch_queue;
    import xgriscv_fetch_queue_pkg::*;

    logic clk;
    logic reset;
    int   checks_total;
    int   checks_passed;
    int   checks_failed;

    xgriscv_fetch_queue_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) fq_if ();

    xgriscv_fetch_queue #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq_if)
    );

    // Combinational instruction memory: the word encodes its own address
    assign fq_if.imem_rdata = 32'hA000_0000 | fq_if.imem_addr;

    // Free-running clock
    always #5 clk = ~clk;

    // Move to the next falling edge, drive inputs, let the head settle
    task automatic applyStimulus(input logic valid, input logic ready,
                                 input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        fq_if.imem_valid  = valid;
        fq_if.dec_ready   = ready;
        fq_if.redirect    = redir;
        fq_if.redirect_pc = rpc;
        #1;
    endtask

    // One immediate-assertion comparison
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Head entry check for a given expected pc
    task automatic checkHead(input string tag, input logic [31:0] pc);
        checkOutput({tag, "_valid"}, 32'(fq_if.dec_valid), 32'd1);
        checkOutput({tag, "_pc"}, fq_if.dec_pc, pc);
        checkOutput({tag, "_pcplus4"}, fq_if.dec_pcplus4, pc + 32'd4);
        checkOutput({tag, "_instr"}, fq_if.dec_instr, 32'hA000_0000 | pc);
    endtask

    initial begin
        checks_total      = 0;
        checks_passed     = 0;
        checks_failed     = 0;
        clk               = 1'b0;
        reset             = 1'b1;
        fq_if.imem_valid  = 1'b1;
        fq_if.dec_ready   = 1'b0;
        fq_if.redirect    = 1'b0;
        fq_if.redirect_pc = 32'h0;
        #1;

        // Reset state
        checkOutput("rst_req", 32'(fq_if.imem_req), 32'd0);
        checkOutput("rst_count", 32'(fq_if.q_count), 32'd0);
        checkOutput("rst_valid", 32'(fq_if.dec_valid), 32'd0);
        checkOutput("rst_instr", fq_if.dec_instr, 32'h0000_0013);
        checkOutput("rst_pc", fq_if.dec_pc, 32'h0);
        checkOutput("rst_pcplus4", fq_if.dec_pcplus4, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        #1;

        // Fill with decode stalled: addresses 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill_addr", fq_if.imem_addr, 32'(4 * i));
            checkOutput("fill_req", 32'(fq_if.imem_req), 32'd1);
            checkOutput("fill_count", 32'(fq_if.q_count), 32'(i));
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("full_req", 32'(fq_if.imem_req), 32'd0);
        checkOutput("full_addr", fq_if.imem_addr, 32'h10);
        checkOutput("full_count", 32'(fq_if.q_count), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("hold_addr", fq_if.imem_addr, 32'h10);
        checkOutput("hold_count", 32'(fq_if.q_count), 32'd4);
        checkHead("hold_head", 32'h0);

        // Decode drains while the full queue keeps fetching
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkHead("drain_head", 32'(4 * j));
            checkOutput("fullpop_req", 32'(fq_if.imem_req), 32'd1);
            checkOutput("fullpop_addr", fq_if.imem_addr, 32'(32'h10 + 4 * j));
            checkOutput("fullpop_count", 32'(fq_if.q_count), 32'd4);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("nolost_head", 32'h10);
        checkOutput("nolost_count", 32'(fq_if.q_count), 32'd4);
        checkOutput("nolost_addr", fq_if.imem_addr, 32'h20);

        // Redirect with three entries queued; same-cycle head still visible
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
        checkOutput("redir_count_before", 32'(fq_if.q_count), 32'd3);
        checkHead("redir_head", 32'h14);
        checkOutput("redir_req", 32'(fq_if.imem_req), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_count", 32'(fq_if.q_count), 32'd0);
        checkOutput("flush_valid", 32'(fq_if.dec_valid), 32'd0);
        checkOutput("flush_instr", fq_if.dec_instr, 32'h0000_0013);
        checkOutput("flush_addr", fq_if.imem_addr, 32'h80);
        checkOutput("flush_req", 32'(fq_if.imem_req), 32'd1);

        // Streaming from the redirect target: one entry in flight each cycle
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkHead("stream_head", 32'(32'h80 + 4 * k));
            checkOutput("stream_count", 32'(fq_if.q_count), 32'd1);
        end

        // Redirect to 0 with decode stalled, then wait states 1,0,0,1
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("ws_addr0", fq_if.imem_addr, 32'h0);
        checkOutput("ws_count0", 32'(fq_if.q_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("ws_addr1", fq_if.imem_addr, 32'h4);
        checkOutput("ws_count1", 32'(fq_if.q_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("ws_addr2", fq_if.imem_addr, 32'h4);
        checkOutput("ws_req2", 32'(fq_if.imem_req), 32'd1);
        checkOutput("ws_count2", 32'(fq_if.q_count), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("ws_addr3", fq_if.imem_addr, 32'h4);
        checkOutput("ws_count3", 32'(fq_if.q_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("ws_count_final", 32'(fq_if.q_count), 32'd2);
        checkOutput("ws_addr_final", fq_if.imem_addr, 32'h8);
        checkHead("ws_head", 32'h0);

        // Asynchronous reset mid-cycle with two entries queued
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(fq_if.dec_valid), 32'd0);
        checkOutput("midrst_count", 32'(fq_if.q_count), 32'd0);
        checkOutput("midrst_req", 32'(fq_if.imem_req), 32'd0);
        checkOutput("midrst_instr", fq_if.dec_instr, 32'h0000_0013);
        @(negedge clk);
        reset = 1'b0;
        fq_if.imem_valid = 1'b0;
        #1;
        checkOutput("post_rst_addr", fq_if.imem_addr, 32'h0);
        checkOutput("post_rst_req", 32'(fq_if.imem_req), 32'd1);
        checkOutput("post_rst_count", 32'(fq_if.q_count), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
